// File: rtl/bias_add_mc.sv
// Two-stage bias-add for the LSTM gate lanes: per-gate bias tables indexed by a channel sequencer.
// Define BIAS_SAT_EN to clamp overflowing sums and drive sat_flag; otherwise sums wrap.
module bias_add_mc #(
   parameter int DWIDTH = 16,
   parameter int GATES  = 4,
   parameter int DEPTH  = 8
) (
   input  logic                       clk,
   input  logic                       xrst,
   input  logic                       mem_we,
   input  logic [$clog2(GATES)-1:0]   mem_gate,
   input  logic [$clog2(DEPTH)-1:0]   mem_addr,
   input  logic signed [DWIDTH-1:0]   mem_wdata,
   input  logic [$clog2(DEPTH):0]     len,
   input  logic                       clear,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [GATES*DWIDTH-1:0]    in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [GATES*DWIDTH-1:0]    out_data,
   output logic [$clog2(DEPTH)-1:0]   out_chan,
   output logic                       out_last,
   output logic                       sat_flag
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
   localparam logic [AW:0] ONE_L   = (AW+1)'(1);

`ifdef BIAS_SAT_EN
   function automatic logic signed [DWIDTH-1:0] sat_add(input logic signed [DWIDTH-1:0] d,
                                                        input logic signed [DWIDTH-1:0] b);
      logic signed [DWIDTH:0] s;
      s = {d[DWIDTH-1], d} + {b[DWIDTH-1], b};
      if (s[DWIDTH] != s[DWIDTH-1])
         return s[DWIDTH] ? {1'b1, {(DWIDTH-1){1'b0}}} : {1'b0, {(DWIDTH-1){1'b1}}};
      return s[DWIDTH-1:0];
   endfunction

   function automatic logic add_ovf(input logic signed [DWIDTH-1:0] d,
                                    input logic signed [DWIDTH-1:0] b);
      logic signed [DWIDTH:0] s;
      s = {d[DWIDTH-1], d} + {b[DWIDTH-1], b};
      return s[DWIDTH] != s[DWIDTH-1];
   endfunction
`else
   // The low DWIDTH bits of the widened sum equal the plain DWIDTH-bit sum.
   function automatic logic signed [DWIDTH-1:0] wrap_add(input logic signed [DWIDTH-1:0] d,
                                                         input logic signed [DWIDTH-1:0] b);
      return d + b;
   endfunction
`endif

   logic signed [DWIDTH-1:0] tbl_q [GATES][DEPTH];

   logic                      en, acc;
   logic [AW-1:0]             cnt_q, cnt_d, tag;
   logic [AW:0]               eff_len, tag_inc;
   logic                      last_d;

   logic                      vld_p1_q;
   logic [GATES*DWIDTH-1:0]   data_p1_q;
   logic signed [DWIDTH-1:0]  bias_p1_q [GATES];
   logic [AW-1:0]             chan_p1_q;
   logic                      last_p1_q;

   logic                      out_valid_q;
   logic [GATES*DWIDTH-1:0]   out_data_q, out_data_d;
   logic [AW-1:0]             out_chan_q;
   logic                      out_last_q;

   assign en       = !out_valid_q || out_ready;
   assign acc      = in_valid && en;
   assign in_ready = en;

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_chan  = out_chan_q;
   assign out_last  = out_last_q;

   // Channel sequencer: a clear in the accepting cycle retags that beat as channel 0.
   assign eff_len = (len == '0) ? DEPTH_L : len;
   assign tag     = clear ? '0 : cnt_q;
   assign tag_inc = {1'b0, tag} + ONE_L;
   assign last_d  = ({1'b0, tag} == (eff_len - ONE_L));

   always_comb begin
      cnt_d = cnt_q;
      if (acc)
         cnt_d = (tag_inc >= eff_len) ? '0 : tag_inc[AW-1:0];
      else if (clear)
         cnt_d = '0;
   end

   always_ff @(posedge clk) begin
      if (mem_we)
         tbl_q[mem_gate][mem_addr] <= mem_wdata;
   end

   // Stage 1: capture the beat and read every gate table at its channel (old data on a same-cycle write).
   always_ff @(posedge clk) begin
      if (acc) begin
         data_p1_q <= in_data;
         chan_p1_q <= tag;
         last_p1_q <= last_d;
         for (int g = 0; g < GATES; g++)
            bias_p1_q[g] <= tbl_q[g][tag];
      end
   end

`ifdef BIAS_SAT_EN
   logic sat_any, sat_q;
`endif

   always_comb begin
      out_data_d = '0;
`ifdef BIAS_SAT_EN
      sat_any = 1'b0;
`endif
      for (int g = 0; g < GATES; g++) begin
`ifdef BIAS_SAT_EN
         out_data_d[g*DWIDTH +: DWIDTH] = sat_add(data_p1_q[g*DWIDTH +: DWIDTH], bias_p1_q[g]);
         sat_any = sat_any | add_ovf(data_p1_q[g*DWIDTH +: DWIDTH], bias_p1_q[g]);
`else
         out_data_d[g*DWIDTH +: DWIDTH] = wrap_add(data_p1_q[g*DWIDTH +: DWIDTH], bias_p1_q[g]);
`endif
      end
   end

   // Stage 2: register the biased lanes; both stages freeze together while en is low.
   always_ff @(posedge clk or negedge xrst) begin
      if (!xrst) begin
         cnt_q       <= '0;
         vld_p1_q    <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_chan_q  <= '0;
         out_last_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         if (en) begin
            vld_p1_q    <= in_valid;
            out_valid_q <= vld_p1_q;
            if (vld_p1_q) begin
               out_data_q <= out_data_d;
               out_chan_q <= chan_p1_q;
               out_last_q <= last_p1_q;
            end
         end
      end
   end

`ifdef BIAS_SAT_EN
   always_ff @(posedge clk or negedge xrst) begin
      if (!xrst)
         sat_q <= 1'b0;
      else
         sat_q <= (sat_q && !clear) || (en && vld_p1_q && sat_any);
   end
   assign sat_flag = sat_q;
`else
   assign sat_flag = 1'b0;
`endif

endmodule

// File: tb/tb_bias_add_mc.sv
// Directed and randomized bench for bias_add_mc against a queue-based reference model.
module tb_bias_add_mc;

   localparam int DW = 16;
   localparam int G  = 4;
   localparam int D  = 8;
   localparam int AW = 3;

`ifdef BIAS_SAT_EN
   localparam logic [15:0] SAT_L0 = 16'h7FFF;
   localparam logic [15:0] SAT_L1 = 16'h8000;
   localparam logic        SAT_F  = 1'b1;
`else
   localparam logic [15:0] SAT_L0 = 16'h8010;
   localparam logic [15:0] SAT_L1 = 16'h7FFF;
   localparam logic        SAT_F  = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              xrst;
   logic              mem_we;
   logic [1:0]        mem_gate;
   logic [AW-1:0]     mem_addr;
   logic [DW-1:0]     mem_wdata;
   logic [AW:0]       len;
   logic              clear;
   logic              in_valid;
   logic              in_ready;
   logic [G*DW-1:0]   in_data;
   logic              out_valid;
   logic              out_ready;
   logic [G*DW-1:0]   out_data;
   logic [AW-1:0]     out_chan;
   logic              out_last;
   logic              sat_flag;

   always #5 clk = ~clk;

   bias_add_mc #(.DWIDTH(DW), .GATES(G), .DEPTH(D)) dut (
      .clk(clk), .xrst(xrst), .mem_we(mem_we), .mem_gate(mem_gate), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .len(len), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_chan(out_chan), .out_last(out_last), .sat_flag(sat_flag)
   );

   typedef struct {
      logic [G*DW-1:0] data;
      int              chan;
      logic            last;
   } beat_t;

   int              nchk = 0;
   int              nerr = 0;
   beat_t           expq[$];
   logic [G*DW-1:0] hist_data[$];
   int              hist_chan[$];
   logic            hist_last[$];
   int              tbl_m [G][D];
   int              cnt_m;
   logic            sat_m;
   logic            acc_flag;
   logic [G*DW-1:0] cap;
   int              nacc;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int eff_len();
      return (len == 0) ? D : int'(len);
   endfunction

   function automatic logic [G*DW-1:0] rep(input logic [DW-1:0] v);
      return {G{v}};
   endfunction

   // Reference: signed lane + bias in plain integer arithmetic, then clamp or wrap.
   task automatic model_sum(input logic [G*DW-1:0] din, input int ch, output logic [G*DW-1:0] r);
      int d, s;
      r = '0;
      for (int g = 0; g < G; g++) begin
         d = $signed(din[g*DW +: DW]);
         s = d + tbl_m[g][ch];
`ifdef BIAS_SAT_EN
         if (s > 32767) begin s = 32767; sat_m = 1'b1; end
         else if (s < -32768) begin s = -32768; sat_m = 1'b1; end
`endif
         r[g*DW +: DW] = s[DW-1:0];
      end
   endtask

   task automatic cyc();
      beat_t e;
      int tag, el;
      #1;
      if (out_valid && out_ready) begin
         if (expq.size() == 0) begin
            check("unexpected_beat", 64'(out_valid), 64'(0));
         end else begin
            e = expq.pop_front();
            check("out_data", out_data, e.data);
            check("out_chan", 64'(out_chan), 64'(e.chan));
            check("out_last", 64'(out_last), 64'(e.last));
         end
         hist_data.push_back(out_data);
         hist_chan.push_back(int'(out_chan));
         hist_last.push_back(out_last);
      end
      if (clear) sat_m = 1'b0;
      acc_flag = in_valid && in_ready;
      if (acc_flag) begin
         tag = clear ? 0 : cnt_m;
         el  = eff_len();
         model_sum(in_data, tag, e.data);
         e.chan = tag;
         e.last = (tag == el - 1);
         expq.push_back(e);
         cnt_m = (tag + 1 >= el) ? 0 : tag + 1;
      end else if (clear) begin
         cnt_m = 0;
      end
      if (mem_we) tbl_m[mem_gate][mem_addr] = $signed(mem_wdata);
      @(posedge clk);
      #1;
      mem_we = 1'b0;
      clear  = 1'b0;
   endtask

   task automatic write(input int g, input int a, input logic [DW-1:0] v);
      mem_we = 1'b1; mem_gate = 2'(g); mem_addr = AW'(a); mem_wdata = v;
      cyc();
   endtask

   task automatic send(input logic [G*DW-1:0] d, input logic clr);
      in_valid = 1'b1; in_data = d; clear = clr;
      for (int k = 0; k < 50; k++) begin
         cyc();
         if (acc_flag) break;
      end
      check("send_accepted", 64'(acc_flag), 64'(1));
      in_valid = 1'b0;
   endtask

   task automatic drain();
      in_valid = 1'b0; out_ready = 1'b1;
      for (int k = 0; k < 40; k++) begin
         if (expq.size() == 0 && !out_valid) break;
         cyc();
      end
      check("drain_empty", 64'(expq.size()), 64'(0));
   endtask

   task automatic hist_reset();
      hist_data.delete(); hist_chan.delete(); hist_last.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      xrst = 1'b0; mem_we = 1'b0; mem_gate = '0; mem_addr = '0; mem_wdata = '0;
      len = 4; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      cnt_m = 0; sat_m = 1'b0; acc_flag = 1'b0; nacc = 0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_out_data", out_data, 64'(0));
      check("rst_out_chan", 64'(out_chan), 64'(0));
      check("rst_out_last", 64'(out_last), 64'(0));
      check("rst_sat_flag", 64'(sat_flag), 64'(0));
      check("rst_in_ready", 64'(in_ready), 64'(1));
      xrst = 1'b1;

      for (int g = 0; g < G; g++)
         for (int a = 0; a < D; a++)
            write(g, a, '0);

      // Basic add with latency probe
      for (int a = 0; a < 4; a++) write(0, a, 16'(10 * (a + 1)));
      hist_reset();
      in_valid = 1'b1; in_data = rep(16'd1);
      cyc();
      check("latency_c1", 64'(out_valid), 64'(0));
      cyc();
      check("latency_c2", 64'(out_valid), 64'(1));
      cyc(); cyc();
      drain();
      check("basic_n", 64'(hist_data.size()), 64'(4));
      check("basic_g0_b0", 64'(hist_data[0][15:0]), 64'(11));
      check("basic_g0_b3", 64'(hist_data[3][15:0]), 64'(41));
      check("basic_g3_b2", 64'(hist_data[2][63:48]), 64'(1));
      check("basic_last_b2", 64'(hist_last[2]), 64'(0));
      check("basic_last_b3", 64'(hist_last[3]), 64'(1));

      // Wrap with len=4, then len=0 (full depth)
      hist_reset();
      for (int i = 0; i < 6; i++) send(rep(16'(i)), 1'b0);
      drain();
      check("wrap_chan4", 64'(hist_chan[4]), 64'(0));
      check("wrap_chan5", 64'(hist_chan[5]), 64'(1));
      check("wrap_last3", 64'(hist_last[3]), 64'(1));
      check("wrap_last5", 64'(hist_last[5]), 64'(0));
      len = 0;
      hist_reset();
      send(rep(16'd0), 1'b1);
      for (int i = 1; i < 9; i++) send(rep(16'(i)), 1'b0);
      drain();
      check("len0_chan7", 64'(hist_chan[7]), 64'(7));
      check("len0_last7", 64'(hist_last[7]), 64'(1));
      check("len0_chan8", 64'(hist_chan[8]), 64'(0));

      // Backpressure: out_ready low for three cycles mid-stream
      len = 4;
      hist_reset();
      nacc = 0;
      in_valid = 1'b1; in_data = rep(16'd100);
      for (int c = 0; c < 40 && nacc < 14; c++) begin
         out_ready = (c >= 4 && c < 7) ? 1'b0 : 1'b1;
         if (c == 4) cap = out_data;
         cyc();
         if (acc_flag) begin
            nacc++;
            in_data = rep(16'(100 + nacc));
         end
         if (c >= 4 && c < 7) begin
            check("bp_in_ready", 64'(in_ready), 64'(0));
            check("bp_hold_data", out_data, cap);
         end
      end
      drain();
      check("bp_count", 64'(hist_data.size()), 64'(nacc));

      // Saturation / wrap corner
      clear = 1'b1; cyc();
      write(0, 0, 16'h0020);
      write(1, 0, 16'hFFFF);
      hist_reset();
      send({16'h0, 16'h0, 16'h8000, 16'h7FF0}, 1'b1);
      drain();
      check("sat_lane0", 64'(hist_data[0][15:0]), 64'(SAT_L0));
      check("sat_lane1", 64'(hist_data[0][31:16]), 64'(SAT_L1));
      check("sat_flag_set", 64'(sat_flag), 64'(SAT_F));
      repeat (3) cyc();
      check("sat_flag_sticky", 64'(sat_flag), 64'(sat_m));
      clear = 1'b1; cyc();
      check("sat_flag_clr", 64'(sat_flag), 64'(0));
      write(0, 0, 16'd10);
      write(1, 0, 16'd0);

      // clear with accepted beat, and read-before-write hazard
      hist_reset();
      send(rep(16'd0), 1'b0);
      send(rep(16'd0), 1'b0);
      send(rep(16'd0), 1'b1);
      send(rep(16'd0), 1'b0);
      mem_we = 1'b1; mem_gate = 2'd0; mem_addr = 3'd2; mem_wdata = 16'd200;
      send(rep(16'd0), 1'b0);
      for (int i = 0; i < 4; i++) send(rep(16'd0), 1'b0);
      drain();
      check("clr_chan", 64'(hist_chan[2]), 64'(0));
      check("clr_next", 64'(hist_chan[3]), 64'(1));
      check("rbw_old", 64'(hist_data[4][15:0]), 64'(30));
      check("rbw_new", 64'(hist_data[8][15:0]), 64'(200));

      // Asynchronous reset mid-stream
      hist_reset();
      in_valid = 1'b1; in_data = rep(16'h7FFF);
      cyc(); cyc(); cyc();
      check("pre_rst_valid", 64'(out_valid), 64'(1));
      check("pre_rst_sat", 64'(sat_flag), 64'(sat_m));
      xrst = 1'b0; in_valid = 1'b0;
      #1;
      check("async_rst_valid", 64'(out_valid), 64'(0));
      check("async_rst_sat", 64'(sat_flag), 64'(0));
      expq.delete(); cnt_m = 0; sat_m = 1'b0;
      @(posedge clk);
      #1;
      xrst = 1'b1;
      hist_reset();
      send(rep(16'd5), 1'b0);
      drain();
      check("post_rst_n", 64'(hist_data.size()), 64'(1));
      check("post_rst_chan", 64'(hist_chan[0]), 64'(0));
      check("post_rst_bias", 64'(hist_data[0][15:0]), 64'(15));

      // Randomized traffic with live table writes and backpressure
      for (int seg = 0; seg < 3; seg++) begin
         len = (AW+1)'($urandom_range(0, D));
         for (int c = 0; c < 250; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = {$urandom, $urandom};
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) begin
               mem_we    = 1'b1;
               mem_gate  = 2'($urandom_range(0, G - 1));
               mem_addr  = AW'($urandom_range(0, D - 1));
               mem_wdata = 16'($urandom);
            end
            cyc();
         end
         drain();
         check("rand_sat_flag", 64'(sat_flag), 64'(sat_m));
      end

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
